// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I main control FSM
//
// Moore-style sequencer for a multicycle RV32I datapath built around one
// shared ALU, a unified instruction/data memory and an immediate extender.
//
// Build option: MCCTRL_ILLEGAL_TRAP_EN
//   defined   - an unsupported opcode enters a sticky TRAP state (illegal = 1)
//   undefined - an unsupported opcode retires as a 2-cycle nop, illegal = 0
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   op, funct3, funct7b5 instruction fields from the instruction register
//   zero                ALU zero flag (branch decision)
//   mem_ready           memory access complete handshake
//   pc_write, ir_write, reg_write, mem_write   datapath write enables
//   adr_src, result_src, alu_src_a, alu_src_b  datapath mux selects
//   imm_src             immediate extender format
//   alu_control         ALU operation
//   illegal             unsupported opcode trapped

module multicycle_ctrl #(
    parameter int ST_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal
);

    localparam logic [ST_W-1:0] S_FETCH    = ST_W'(0);
    localparam logic [ST_W-1:0] S_DECODE   = ST_W'(1);
    localparam logic [ST_W-1:0] S_MEMADR   = ST_W'(2);
    localparam logic [ST_W-1:0] S_MEMREAD  = ST_W'(3);
    localparam logic [ST_W-1:0] S_MEMWB    = ST_W'(4);
    localparam logic [ST_W-1:0] S_MEMWRITE = ST_W'(5);
    localparam logic [ST_W-1:0] S_EXECR    = ST_W'(6);
    localparam logic [ST_W-1:0] S_EXECI    = ST_W'(7);
    localparam logic [ST_W-1:0] S_ALUWB    = ST_W'(8);
    localparam logic [ST_W-1:0] S_BEQ      = ST_W'(9);
    localparam logic [ST_W-1:0] S_JAL      = ST_W'(10);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    localparam logic [ST_W-1:0] S_TRAP     = ST_W'(11);
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_next;

    // Write enables before reset gating.
    logic pc_write_int;
    logic mem_write_int;
    logic ir_write_int;
    logic reg_write_int;

    // Sub only for R-type (op[5] = 1) with funct7 bit 30 set; I-type addi
    // never subtracts regardless of immediate bit 30.
    function automatic logic [2:0] funct_alu(input logic [2:0] f3,
                                             input logic       op5,
                                             input logic       f7b5);
        case (f3)
            3'b000:  funct_alu = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_next = S_MEMADR;
                    OP_RTYPE:  state_next = S_EXECR;
                    OP_ITYPE:  state_next = S_EXECI;
                    OP_BRANCH: state_next = S_BEQ;
                    OP_JAL:    state_next = S_JAL;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                    default:   state_next = S_TRAP;
`else
                    default:   state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_MEMWB,
            S_ALUWB,
            S_BEQ:      state_next = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_next = S_ALUWB;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_next = S_TRAP;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_int  = 1'b0;
        mem_write_int = 1'b0;
        ir_write_int  = 1'b0;
        reg_write_int = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_control   = ALU_ADD;
        case (state)
            S_FETCH: begin
                // PC + 4 computed every FETCH cycle, committed only once the
                // instruction word has actually arrived.
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                ir_write_int = mem_ready;
                pc_write_int = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_int = 1'b1;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_int = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = funct_alu(funct3, op[5], funct7b5);
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = funct_alu(funct3, op[5], funct7b5);
            end
            S_ALUWB: begin
                reg_write_int = 1'b1;
            end
            S_BEQ: begin
                alu_src_a    = 2'b10;
                alu_control  = ALU_SUB;
                pc_write_int = zero;
            end
            S_JAL: begin
                // Return address OldPC + 4 goes through the ALU while the
                // jump target (computed in DECODE) sits in ALUOut.
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_int = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // Reset masks enables combinationally so an aborted store or write-back
    // cannot commit during the reset cycle itself.
    assign pc_write  = pc_write_int  & rst_n;
    assign mem_write = mem_write_int & rst_n;
    assign ir_write  = ir_write_int  & rst_n;
    assign reg_write = reg_write_int & rst_n;

`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign illegal = (state == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the team's multicycle RV32I core. It is a Moore-style state machine that sequences one shared ALU, a unified instruction/data memory and the immediate extender across several cycles per instruction. It decodes `op`, `funct3` and `funct7b5` into the per-cycle datapath selects and write enables. It drives the extender's `ImmSrc` select and waits on a memory ready handshake.

## Interface
- `ST_W`, default 4: state register width. It must hold 12 states.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `op`  in  7  instruction opcode, taken from the instruction register.
- `funct3`  in  3  instruction bits 14:12.
- `funct7b5`  in  1  instruction bit 30.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current access.
- `pc_write`  out  1  PC register enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  instruction and OldPC register enable.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b`  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `imm_src`  out  2  extender format: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control`  out  3  ALU op: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `illegal`  out  1  unsupported opcode trapped (see Configuration).

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- **Transitions:**
  - FETCH → DECODE, only when `mem_ready` = 1; otherwise FETCH holds.
  - DECODE → MEMADR for `op` 0000011 or 0100011.
  - DECODE → EXECR for 0110011, EXECI for 0010011, BEQ for 1100011, JAL for 1101111.
  - DECODE → FETCH or TRAP for any other opcode (see Configuration).
  - MEMADR → MEMREAD for a load (`op[5]` = 0), MEMWRITE for a store.
  - MEMREAD → MEMWB when `mem_ready` = 1; otherwise it holds.
  - MEMWRITE → FETCH when `mem_ready` = 1; otherwise it holds.
  - MEMWB, ALUWB and BEQ → FETCH.
  - EXECR, EXECI and JAL → ALUWB.
- **Per-state outputs.** Any field not listed for a state is 0.
  - FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, add, result_src 10. `ir_write` and `pc_write` are high only in cycles where `mem_ready` = 1.
  - DECODE: alu_src_a 01, alu_src_b 01, add (computes the branch target).
  - MEMADR: alu_src_a 10, alu_src_b 01, add.
  - MEMREAD: adr_src 1, result_src 00.
  - MEMWRITE: adr_src 1, result_src 00, mem_write 1 held for the whole state.
  - MEMWB: result_src 01, reg_write 1.
  - EXECR: alu_src_a 10, alu_src_b 00, funct decode.
  - EXECI: alu_src_a 10, alu_src_b 01, funct decode.
  - ALUWB: result_src 00, reg_write 1.
  - BEQ: alu_src_a 10, alu_src_b 00, sub, result_src 00, `pc_write` = `zero`.
  - JAL: alu_src_a 01, alu_src_b 10, add, result_src 00, pc_write 1.
  - TRAP: no enable is asserted and `illegal` = 1.
- **`imm_src`** is combinational from `op`, independent of state: 0000011 and 0010011 → 00, 0100011 → 01, 1100011 → 10, 1101111 → 11, any other opcode → 00.
- **Funct decode** (EXECR, EXECI):
  - funct3 000 → sub if `op[5]` & `funct7b5`, else add.
  - funct3 010 → slt, 110 → or, 111 → and.
  - Any other funct3 → add.
- **Reset:**
  - While `rst_n` = 0, `pc_write`, `ir_write`, `reg_write` and `mem_write` are forced to 0 combinationally.
  - The state is FETCH after the first clock edge with `rst_n` = 0.
  - Reset asserted in any state, including a wait in MEMWRITE or MEMREAD, aborts the instruction. No write enable is asserted during that reset cycle.
- **Reset values of outputs (FETCH with `rst_n` high):** all 0 except alu_src_b = 10 and result_src = 10. `ir_write` and `pc_write` follow `mem_ready`.

## Timing
- Instruction latency with `mem_ready` tied high:
  - lw: 5 cycles.
  - sw, R-type, I-type ALU, jal: 4 cycles.
  - beq: 3 cycles.
- Each low cycle of `mem_ready` in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- State updates on the rising edge of `clk`. All outputs are combinational from state, `op`, `funct3`, `funct7b5`, `zero` and `mem_ready`, with no extra register stage.

## Configuration
- **`MCCTRL_ILLEGAL_TRAP_EN` defined:**
  - An unsupported opcode in DECODE → TRAP.
  - TRAP is sticky until reset and `illegal` = 1 while in it.
- **Not defined:**
  - An unsupported opcode in DECODE → FETCH, executing as a 2-cycle nop.
  - `illegal` is tied to 0 and the TRAP state is not implemented.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with `mem_ready` = 1 → all write enables 0. After release, state is FETCH with alu_src_b = 10 and result_src = 10.
- **Load with waits:** lw (`op` 0000011) with `mem_ready` low 2 cycles in FETCH and 1 cycle in MEMREAD → 8 cycles total. `reg_write` pulses once in MEMWB with result_src = 01. `imm_src` = 00.
- **Store with wait:** sw with `mem_ready` low 1 cycle in MEMWRITE → `mem_write` high for 2 consecutive cycles with adr_src = 1, then FETCH. `imm_src` = 01.
- **Branch:** beq with `zero` = 1 → `pc_write` = 1 in the 3rd cycle with alu_control = 001. With `zero` = 0 → `pc_write` = 0 in BEQ. `imm_src` = 10 in both cases.
- **R-type funct decode:** R-type with funct3 000 and `funct7b5` = 1 → alu_control = 001 in EXECR. funct3 111 → 010. funct3 010 → 101.
- **Unsupported opcode:** `op` 0110111 → with the macro, TRAP and `illegal` = 1 held for 10 cycles until reset. Without the macro, back in FETCH on the 3rd cycle with no write enable asserted.
